// File: rtl/display_digit_encoder_if.sv
// rtl/display_digit_encoder_if.sv - request/result bundle between vending control and the digit encoder
interface display_digit_encoder_if #(
   parameter int VAL_W  = 8,
   parameter int DIGITS = 3
);
   logic                  start;
   logic [VAL_W-1:0]      value;
   logic [1:0]            mode;
   logic                  busy;
   logic                  done;
   logic                  overflow;
   logic [4*DIGITS-1:0]   digits_out;

   modport master (output start, value, mode, input busy, done, overflow, digits_out);
   modport slave  (input start, value, mode, output busy, done, overflow, digits_out);
endinterface

// File: rtl/display_digit_encoder.sv
// rtl/display_digit_encoder.sv - double-dabble binary to display-code encoder with blanking, dash, lamp test and blink
module display_digit_encoder #(
   parameter int VAL_W     = 8,
   parameter int DIGITS    = 3,
   parameter int BLINK_DIV = 25000000
) (
   input logic                    clk,
   input logic                    rst,
   display_digit_encoder_if.slave bus
);
   localparam int DW = 4 * DIGITS;
   localparam int CW = $clog2(VAL_W + 1);
   localparam int BW = $clog2(BLINK_DIV + 1);

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < n; i++) p = p * 64'd10;
      return p;
   endfunction

   localparam logic [63:0] LIMIT = pow10(DIGITS);

   typedef enum logic [1:0] {IDLE, CONV, FMT} state_t;

   state_t           state, state_next;
   logic [VAL_W-1:0] val_sh;
   logic [DW-1:0]    bcd, bcd_adj, bcd_step, fmt_digits, held;
   logic [CW-1:0]    cnt;
   logic [1:0]       mode_q;
   logic             ovf, done_q, blink_en, phase;
   logic [BW-1:0]    blink_cnt;
   int               msd;

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.start) state_next = CONV;
         CONV:    if (cnt == CW'(1)) state_next = FMT;
         FMT:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < DIGITS; i++)
         if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      bcd_step = {bcd_adj[DW-2:0], val_sh[VAL_W-1]};
   end

   // msd is the highest non-zero digit; a zero value still shows digit 0
   always_comb begin
      msd = 0;
      for (int i = 0; i < DIGITS; i++)
         if (bcd[4*i +: 4] != 4'd0) msd = i;
      fmt_digits = '1;
      if (mode_q == 2'd2) begin
         fmt_digits = {DIGITS{4'b1000}};
      end else if (ovf) begin
         fmt_digits = {DIGITS{4'b1110}};
      end else begin
         for (int i = 0; i < DIGITS; i++) begin
            if (i <= msd)
               fmt_digits[4*i +: 4] = bcd[4*i +: 4];
            else if (mode_q == 2'd1 && i == msd + 1)
               fmt_digits[4*i +: 4] = 4'b1110;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         val_sh    <= '0;
         bcd       <= '0;
         cnt       <= '0;
         mode_q    <= '0;
         ovf       <= 1'b0;
         done_q    <= 1'b0;
         held      <= '1;
         blink_en  <= 1'b0;
         phase     <= 1'b0;
         blink_cnt <= '0;
      end else begin
         state  <= state_next;
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  val_sh <= bus.value;
                  mode_q <= bus.mode;
                  ovf    <= (bus.mode != 2'd2) && (64'(bus.value) >= LIMIT);
                  bcd    <= '0;
                  cnt    <= CW'(VAL_W);
               end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
                  blink_cnt <= '0;
                  phase     <= ~phase;
               end else begin
                  blink_cnt <= blink_cnt + 1'b1;
               end
            end
            CONV: begin
               bcd    <= bcd_step;
               val_sh <= {val_sh[VAL_W-2:0], 1'b0};
               cnt    <= cnt - 1'b1;
            end
            FMT: begin
               held      <= fmt_digits;
               done_q    <= 1'b1;
               blink_en  <= (mode_q == 2'd3);
               blink_cnt <= '0;
               phase     <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // blink state is only updated in IDLE and FMT, so it stays frozen during a conversion
   assign bus.busy       = (state != IDLE);
   assign bus.done       = done_q;
   assign bus.overflow   = ovf;
   assign bus.digits_out = (blink_en && phase) ? '1 : held;
endmodule
